gain_offset_cal: RTL and testbench

Automatic calibration engine that produces the `gain`/`offset` pair consumed by the downstream gain/offset/clamp stage. On a `start` pulse it captures the min and max of a window of valid input samples. It then computes the Q-format gain that maps the observed span onto the full symmetric output range, and the offset that centres the span on zero. It sits beside the gain/offset/clamp stage on the same sample stream; its outputs feed that stage's `gain` and `offset` inputs, typically via a register-bank mux.

---
 rtl/gain_offset_cal_pkg.sv | 34 +++
 rtl/gain_offset_cal_if.sv | 27 ++
 rtl/restoring_divider.sv | 61 ++++++
 rtl/gain_offset_cal.sv | 178 +++++++++++++++++
 tb/tb_gain_offset_cal.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gain_offset_cal_pkg.sv
// Shared types and helpers for the gain/offset calibration engine:
// FSM state encoding, target-span and gain-limit constants, offset clamp.
package gain_offset_cal_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ACQUIRE = 3'd1;
  localparam state_t ST_DIVIDE  = 3'd2;
  localparam state_t ST_MULT    = 3'd3;
  localparam state_t ST_FINAL   = 3'd4;

  // Full symmetric output span of the downstream stage: 2^out_width - 2.
  function automatic int unsigned target_span(input int unsigned out_width);
    return (32'd1 << out_width) - 32'd2;
  endfunction

  // Largest gain that is still positive when read as a signed value.
  function automatic int unsigned max_gain(input int unsigned gain_width);
    return (32'd1 << (gain_width - 32'd1)) - 32'd1;
  endfunction

  function automatic logic signed [31:0] clamp_offset(input logic signed [31:0] raw,
                                                      input int unsigned    offset_width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (offset_width - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (offset_width - 32'd1));
    if (raw > hi) return hi;
    if (raw < lo) return lo;
    return raw;
  endfunction

endpackage

// File: rtl/gain_offset_cal_if.sv
// Sample-stream and result bundle of gain_offset_cal; the slave side is the
// calibration engine, the master side drives start and samples.
interface gain_offset_cal_if #(
  parameter int IN_WIDTH     = 8,
  parameter int GAIN_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 8
);
  logic                           start;
  logic                           in_valid;
  logic signed [IN_WIDTH-1:0]     in_data;
  logic                           busy;
  logic                           done;
  logic                           cal_valid;
  logic                           degenerate;
  logic        [GAIN_WIDTH-1:0]   gain;
  logic signed [OFFSET_WIDTH-1:0] offset;

  modport master (
    output start, in_valid, in_data,
    input  busy, done, cal_valid, degenerate, gain, offset
  );

  modport slave (
    input  start, in_valid, in_data,
    output busy, done, cal_valid, degenerate, gain, offset
  );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, latency DVD_W cycles
// after start_i. done_o marks the cycle of the last iteration.
module restoring_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] rem_d;
  logic [DVS_W-1:0] dvs_q;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W:0]   partial;
  logic [DVS_W:0]   trial;
  logic             qbit;

  // quo_q shifts dividend bits out of its top while quotient bits enter below.
  always_comb begin
    partial = {rem_q, quo_q[DVD_W-1]};
    trial   = partial - {1'b0, dvs_q};
    qbit    = ~trial[DVS_W];
    rem_d   = qbit ? trial[DVS_W-1:0] : partial[DVS_W-1:0];
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      quo_q  <= dividend_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= {quo_q[DVD_W-2:0], qbit};
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DVD_W - 1)) busy_q <= 1'b0;
    end
  end

  assign done_o     = busy_q && (cnt_q == CNT_W'(DVD_W - 1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/gain_offset_cal.sv
// Calibration engine: windowed min/max capture, then gain = TS<<R / span and
// a centring offset. Define GAIN_OFFSET_CAL_ROUND_EN to round the offset to nearest.
module gain_offset_cal
  import gain_offset_cal_pkg::*;
#(
  parameter int IN_WIDTH     = 8,
  parameter int GAIN_WIDTH   = 16,
  parameter int GAIN_RADIX   = 8,
  parameter int OFFSET_WIDTH = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int WINDOW_LOG2  = 10
) (
  input logic             clk,
  input logic             rst,
  gain_offset_cal_if.slave bus
);

  localparam int D         = OUT_WIDTH + GAIN_RADIX;
  localparam int DIV_CNT_W = $clog2(D + 1);
  localparam int P_W       = IN_WIDTH + 1 + GAIN_WIDTH;
  localparam int RAW_W     = P_W + 1;

  localparam logic [D-1:0]          DIVIDEND = D'(target_span(OUT_WIDTH) << GAIN_RADIX);
  localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = GAIN_WIDTH'(max_gain(GAIN_WIDTH));
  localparam logic [GAIN_WIDTH-1:0] UNITY    = GAIN_WIDTH'(32'd1 << GAIN_RADIX);

  state_t                         state_q, state_d;
  logic [WINDOW_LOG2-1:0]         smp_cnt_q, smp_cnt_d;
  logic [DIV_CNT_W-1:0]           div_cnt_q, div_cnt_d;
  logic signed [IN_WIDTH-1:0]     min_q, min_d, max_q, max_d;
  logic                           busy_q, busy_d, done_q, done_d;
  logic                           cal_valid_q, cal_valid_d, degen_q, degen_d;
  logic [GAIN_WIDTH-1:0]          gain_q, gain_d;
  logic signed [OFFSET_WIDTH-1:0] offset_q, offset_d;

  logic [IN_WIDTH-1:0]            span;
  logic                           span_zero;
  logic                           div_start;
  logic                           div_done;
  logic [D-1:0]                   quotient;
  logic [GAIN_WIDTH-1:0]          gain_sel;
  logic signed [IN_WIDTH:0]       sum;
  logic signed [P_W-1:0]          prod, prod_adj, shifted;
  logic signed [RAW_W-1:0]        raw;
  logic signed [OFFSET_WIDTH-1:0] offset_sel;

  // max >= min always holds, so the wrapped difference is the exact span.
  assign span      = IN_WIDTH'(max_q - min_q);
  assign span_zero = (span == '0);
  assign div_start = (state_q == ST_DIVIDE) && (div_cnt_q == '0) && !span_zero;

  restoring_divider #(
    .DVD_W (D),
    .DVS_W (IN_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (DIVIDEND),
    .divisor_i  (span),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_comb begin
    if (span_zero)                      gain_sel = UNITY;
    else if (32'(quotient) > 32'(GAIN_MAX)) gain_sel = GAIN_MAX;
    else                                gain_sel = GAIN_WIDTH'(quotient);
  end

  assign sum  = (IN_WIDTH + 1)'(max_q) + (IN_WIDTH + 1)'(min_q);
  assign prod = P_W'(sum) * P_W'($signed({1'b0, gain_sel}));

`ifdef GAIN_OFFSET_CAL_ROUND_EN
  localparam logic signed [P_W-1:0] ROUND_BIAS = P_W'(2 ** GAIN_RADIX);
  assign prod_adj = prod + ROUND_BIAS;
`else
  assign prod_adj = prod;
`endif

  assign shifted    = prod_adj >>> (GAIN_RADIX + 1);
  assign raw        = span_zero ? -RAW_W'(min_q) : -RAW_W'(shifted);
  assign offset_sel = OFFSET_WIDTH'(clamp_offset(32'(raw), OFFSET_WIDTH));

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case infers a latch.
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    div_cnt_d   = div_cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cal_valid_d = cal_valid_q;
    degen_d     = degen_q;
    gain_d      = gain_q;
    offset_d    = offset_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_ACQUIRE;
          busy_d    = 1'b1;
          smp_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (bus.in_valid) begin
          smp_cnt_d = smp_cnt_q + WINDOW_LOG2'(1);
          if (smp_cnt_q == '0) begin
            min_d = bus.in_data;
            max_d = bus.in_data;
          end else begin
            if (bus.in_data < min_q) min_d = bus.in_data;
            if (bus.in_data > max_q) max_d = bus.in_data;
          end
          if (smp_cnt_q == '1) begin
            state_d   = ST_DIVIDE;
            div_cnt_d = '0;
          end
        end
      end
      ST_DIVIDE: begin
        // A zero span skips the divider but waits the same number of cycles.
        div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        if (span_zero ? (div_cnt_q == DIV_CNT_W'(D)) : div_done) state_d = ST_MULT;
      end
      ST_MULT: begin
        gain_d      = gain_sel;
        offset_d    = offset_sel;
        degen_d     = span_zero;
        done_d      = 1'b1;
        cal_valid_d = 1'b1;
        state_d     = ST_FINAL;
      end
      ST_FINAL: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      div_cnt_q   <= '0;
      min_q       <= '0;
      max_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cal_valid_q <= 1'b0;
      degen_q     <= 1'b0;
      gain_q      <= UNITY;
      offset_q    <= '0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      div_cnt_q   <= div_cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cal_valid_q <= cal_valid_d;
      degen_q     <= degen_d;
      gain_q      <= gain_d;
      offset_q    <= offset_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cal_valid  = cal_valid_q;
  assign bus.degenerate = degen_q;
  assign bus.gain       = gain_q;
  assign bus.offset     = offset_q;

endmodule

// File: tb/tb_gain_offset_cal.sv
// Self-checking bench for gain_offset_cal (WINDOW_LOG2=2): transaction-level
// model compared every cycle, plus hand-computed literal expectations.
module tb_gain_offset_cal;

  localparam int IN_W       = 8;
  localparam int GAIN_W     = 16;
  localparam int GAIN_RADIX = 8;
  localparam int OFF_W      = 8;
  localparam int OUT_W      = 8;
  localparam int WIN_LOG2   = 2;
  localparam int WIN        = 1 << WIN_LOG2;
  localparam int LAT        = OUT_W + GAIN_RADIX + 3;  // last sample to done

  logic clk = 1'b0;
  logic rst;

  gain_offset_cal_if #(.IN_WIDTH(IN_W), .GAIN_WIDTH(GAIN_W), .OFFSET_WIDTH(OFF_W)) bus ();

  gain_offset_cal #(
    .IN_WIDTH     (IN_W),
    .GAIN_WIDTH   (GAIN_W),
    .GAIN_RADIX   (GAIN_RADIX),
    .OFFSET_WIDTH (OFF_W),
    .OUT_WIDTH    (OUT_W),
    .WINDOW_LOG2  (WIN_LOG2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy, m_done, m_cal, m_degen, m_collect, m_was_busy, m_was_done, cmp_en;
  int m_gain, m_off, m_countdown;
  int m_win[$];

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_result();
    int mn, mx, span, g, p, raw, hi, lo;
    mn = m_win[0];
    mx = m_win[0];
    foreach (m_win[i]) begin
      if (m_win[i] < mn) mn = m_win[i];
      if (m_win[i] > mx) mx = m_win[i];
    end
    span = mx - mn;
    if (span == 0) begin
      g       = 1 << GAIN_RADIX;
      raw     = -mn;
      m_degen = 1'b1;
    end else begin
      g = (((1 << OUT_W) - 2) << GAIN_RADIX) / span;
      if (g > (1 << (GAIN_W - 1)) - 1) g = (1 << (GAIN_W - 1)) - 1;
      p = (mx + mn) * g;
`ifdef GAIN_OFFSET_CAL_ROUND_EN
      raw = -floor_div(p + (1 << GAIN_RADIX), 1 << (GAIN_RADIX + 1));
`else
      raw = -floor_div(p, 1 << (GAIN_RADIX + 1));
`endif
      m_degen = 1'b0;
    end
    hi = (1 << (OFF_W - 1)) - 1;
    lo = -(1 << (OFF_W - 1));
    if (raw > hi) raw = hi;
    if (raw < lo) raw = lo;
    m_gain = g;
    m_off  = raw;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_cal = 0; m_degen = 0; m_collect = 0;
      m_gain = 1 << GAIN_RADIX; m_off = 0; m_countdown = 0;
      m_win.delete();
    end else begin
      m_was_busy = m_busy;
      m_was_done = m_done;
      m_done = 0;
      if (m_was_done) m_busy = 0;
      if (m_countdown > 0) begin
        m_countdown--;
        if (m_countdown == 0) begin
          model_result();
          m_done = 1;
          m_cal  = 1;
        end
      end
      if (!m_was_busy && bus.start) begin
        m_busy = 1; m_collect = 1;
        m_win.delete();
      end else if (m_collect && bus.in_valid) begin
        m_win.push_back(int'($signed(bus.in_data)));
        if (m_win.size() == WIN) begin
          m_collect   = 0;
          m_countdown = LAT - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",       32'(bus.busy),       32'(m_busy));
      check("done",       32'(bus.done),       32'(m_done));
      check("cal_valid",  32'(bus.cal_valid),  32'(m_cal));
      check("degenerate", 32'(bus.degenerate), 32'(m_degen));
      check("gain",       32'(bus.gain),       m_gain);
      check("offset",     32'(bus.offset),     m_off);
    end
  end

  // ---------------- stimulus ----------------
  logic signed [IN_W-1:0] win [WIN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int a, input int b, input int c, input int d);
    win[0] = IN_W'(a); win[1] = IN_W'(b); win[2] = IN_W'(c); win[3] = IN_W'(d);
  endtask

  // Returns cycles from the last window sample to the done pulse.
  task automatic run_window(input string tag, input bit gaps, input bit start_at_done,
                            output int lat);
    int n;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;           // junk in the start cycle must not count
    bus.in_data  = IN_W'($urandom);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_data  = IN_W'($urandom);
        bus.start    = (i == 1);
        tick();
        bus.start = 1'b0;
        if (i == 2) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = win[i];
      tick();
    end
    bus.in_data = IN_W'($urandom);
    n = 1;
    while (bus.done !== 1'b1 && n < 3 * LAT) begin
      tick();
      n++;
      bus.in_data = IN_W'($urandom);
    end
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    if (start_at_done) bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    lat = n;
  endtask

  int lat;
  int done_cnt;
  int exp_off_b, exp_off_e;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_gain",   32'(bus.gain),      32'd256);
    check("rst_offset", 32'(bus.offset),    32'd0);
    check("rst_busy",   32'(bus.busy),      32'd0);
    check("rst_cal",    32'(bus.cal_valid), 32'd0);
    tick();

    set_win(-64, 64, 0, 10);
    run_window("a", 1'b0, 1'b0, lat);
    check("a_latency", lat, 32'd19);
    check("a_gain",    32'(bus.gain),   32'd508);
    check("a_offset",  32'(bus.offset), 32'd0);
    check("a_cal",     32'(bus.cal_valid), 32'd1);

`ifdef GAIN_OFFSET_CAL_ROUND_EN
    exp_off_b = -127;
    exp_off_e = -64;
`else
    exp_off_b = -126;
    exp_off_e = -63;
`endif
    set_win(0, 100, 50, 20);
    run_window("b", 1'b0, 1'b0, lat);
    check("b_gain",   32'(bus.gain),   32'd650);
    check("b_offset", 32'(bus.offset), exp_off_b);

    set_win(5, 5, 5, 5);
    run_window("c", 1'b0, 1'b0, lat);
    check("c_gain",   32'(bus.gain),       32'd256);
    check("c_offset", 32'(bus.offset),     -32'sd5);
    check("c_degen",  32'(bus.degenerate), 32'd1);
    check("c_latency", lat, 32'd19);

    set_win(-128, -128, -128, -128);
    run_window("d", 1'b0, 1'b0, lat);
    check("d_offset", 32'(bus.offset), 32'd127);

    set_win(0, 1, 1, 0);
    run_window("e", 1'b0, 1'b1, lat);
    check("e_gain",   32'(bus.gain),       32'd32767);
    check("e_offset", 32'(bus.offset),     exp_off_e);
    check("e_degen",  32'(bus.degenerate), 32'd0);
    repeat (3) tick();
    check("e_start_at_done_ignored", 32'(bus.busy), 32'd0);

    set_win(0, 100, 50, 20);
    run_window("f", 1'b1, 1'b0, lat);
    check("f_gain",   32'(bus.gain),   32'd650);
    check("f_offset", 32'(bus.offset), exp_off_b);
    check("f_latency", lat, 32'd19);

    // Abort mid-DIVIDE after a good calibration.
    set_win(-64, 64, 0, 10);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      bus.in_valid = 1'b1; bus.in_data = win[i]; tick();
    end
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("g_busy",   32'(bus.busy),      32'd0);
    check("g_gain",   32'(bus.gain),      32'd256);
    check("g_offset", 32'(bus.offset),    32'd0);
    check("g_cal",    32'(bus.cal_valid), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    check("g_no_done", done_cnt, 32'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
